// File: rtl/md_pkg.sv
// md_pkg: shared types and helpers for the HI/LO multiply/divide sequencer.
//   md_op_t    - E-stage HI/LO opcode encoding
//   mu_op_t    - operation codes understood by the `mult` unit
//   md_state_t - sequencer state encoding
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_t;

  typedef enum logic [2:0] {
    MU_NONE  = 3'd0,
    MU_MULT  = 3'd1,
    MU_MULTU = 3'd2,
    MU_DIV   = 3'd3,
    MU_DIVU  = 3'd4
  } mu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } md_state_t;

  function automatic logic is_md_launch(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Launch opcodes 1..4 map one-to-one onto the unit codes 1..4.
  function automatic mu_op_t to_mu_op(input logic [3:0] op);
    return mu_op_t'(op[2:0]);
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// md_ctrl_if: bus between the sequencer and the multi-cycle `mult` unit.
//   mu_start        - one-cycle start pulse (sequencer -> unit)
//   mu_op           - unit operation code (sequencer -> unit)
//   mu_a, mu_b      - operands (sequencer -> unit)
//   mu_busy         - unit busy (unit -> sequencer)
//   mu_hi, mu_lo    - results, valid once busy drops (unit -> sequencer)
interface md_ctrl_if;
  logic        mu_start;
  logic [2:0]  mu_op;
  logic [31:0] mu_a;
  logic [31:0] mu_b;
  logic        mu_busy;
  logic [31:0] mu_hi;
  logic [31:0] mu_lo;

  modport master (output mu_start, mu_op, mu_a, mu_b,
                  input  mu_busy, mu_hi, mu_lo);
  modport slave  (input  mu_start, mu_op, mu_a, mu_b,
                  output mu_busy, mu_hi, mu_lo);
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: sequencer between the E stage and the multiply/divide unit.
// Decodes E-stage HI/LO ops, launches the unit with a one-cycle start,
// owns architectural HI/LO, and stalls dependent D-stage HI/LO ops.
// Ports:
//   clk, reset            - clock, async active-high reset
//   e_valid/e_flush       - E-stage instruction valid / killed
//   e_md_op, e_rs, e_rt   - E-stage opcode and operands
//   d_md_use              - D-stage instruction is a HI/LO op
//   stall, md_busy        - pipeline freeze, sequencer not idle
//   rd_data               - mfhi/mflo result
//   hi, lo                - architectural HI/LO
//   md_err                - sticky timeout / protocol-violation flag
//   mu                    - master side of the `mult` bus
//
// state     | meaning
// ST_IDLE   | ready; launches, mthi/mtlo accepted
// ST_LAUNCH | mu_start high for exactly one cycle
// ST_WAIT   | waiting for mu_busy low, bounded by TIMEOUT
module md_ctrl
  import md_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic        e_flush,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_md_use,
  output logic        stall,
  output logic        md_busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_err,
  md_ctrl_if.master   mu
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  md_state_t     state, state_next;
  logic [CW-1:0] cnt;
  logic          op_live, launch, cnt_last, timeout_hit;

  assign op_live     = e_valid & ~e_flush & (e_md_op != OP_NONE);
  assign launch      = op_live & (state == ST_IDLE) & is_md_launch(e_md_op)
                     & ~(is_div(e_md_op) & (e_rt == 32'd0));
  assign cnt_last    = (cnt == CNT_LAST);
  assign timeout_hit = (state == ST_WAIT) & mu.mu_busy & cnt_last;

  assign md_busy = (state != ST_IDLE);
  assign stall   = d_md_use & (md_busy | launch);

  always_comb begin
    rd_data = 32'd0;
    if (e_md_op == OP_MFHI)      rd_data = hi;
    else if (e_md_op == OP_MFLO) rd_data = lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (launch) state_next = ST_LAUNCH;
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT:   if (!mu.mu_busy || cnt_last) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mu.mu_start <= 1'b0;
      mu.mu_op    <= 3'd0;
      mu.mu_a     <= 32'd0;
      mu.mu_b     <= 32'd0;
      cnt         <= '0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      md_err      <= 1'b0;
    end else begin
      mu.mu_start <= launch;
      if (launch) begin
        mu.mu_op <= to_mu_op(e_md_op);
        mu.mu_a  <= e_rs;
        mu.mu_b  <= e_rt;
      end

      if (state == ST_LAUNCH)
        cnt <= '0;
      else if ((state == ST_WAIT) && mu.mu_busy && !cnt_last)
        cnt <= cnt + 1'b1;

      if ((state == ST_WAIT) && !mu.mu_busy) begin
        hi <= mu.mu_hi;
        lo <= mu.mu_lo;
      end else if ((state == ST_IDLE) && e_valid && !e_flush) begin
        if (e_md_op == OP_MTHI) hi <= e_rs;
        if (e_md_op == OP_MTLO) lo <= e_rs;
      end

      // Any live op issued while an operation is in flight is dropped and flagged.
      if (timeout_hit || (op_live && (state != ST_IDLE)))
        md_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;
  import md_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid, e_flush, d_md_use;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs, e_rt;
  logic        stall, md_busy, md_err;
  logic [31:0] rd_data, hi, lo;
  logic        hang = 1'b0;

  always #5 clk = ~clk;

  md_ctrl_if mu_bus();

  md_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_flush(e_flush),
    .e_md_op(e_md_op), .e_rs(e_rs), .e_rt(e_rt), .d_md_use(d_md_use),
    .stall(stall), .md_busy(md_busy), .rd_data(rd_data), .hi(hi), .lo(lo),
    .md_err(md_err), .mu(mu_bus)
  );

  // Behavioural `mult`: samples start, busy for 5 cycles, results valid when busy drops.
  logic [63:0] mu_res;
  int          mu_cnt;

  function automatic logic [63:0] mu_compute(input logic [2:0] op, input logic [31:0] a, b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd1:    return sa * sb;
      3'd2:    return {32'd0, a} * {32'd0, b};
      3'd3:    return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      3'd4:    return {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mu_bus.mu_busy <= 1'b0;
      mu_bus.mu_hi   <= 32'd0;
      mu_bus.mu_lo   <= 32'd0;
      mu_cnt         <= 0;
    end else if (mu_bus.mu_start) begin
      mu_bus.mu_busy <= 1'b1;
      mu_bus.mu_hi   <= 32'hDEADBEEF;
      mu_bus.mu_lo   <= 32'hDEADBEEF;
      mu_res         <= mu_compute(mu_bus.mu_op, mu_bus.mu_a, mu_bus.mu_b);
      mu_cnt         <= 5;
    end else if (mu_bus.mu_busy && !hang) begin
      if (mu_cnt == 1) begin
        mu_bus.mu_busy <= 1'b0;
        mu_bus.mu_hi   <= mu_res[63:32];
        mu_bus.mu_lo   <= mu_res[31:0];
      end
      mu_cnt <= mu_cnt - 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          exp_busy;
    int          exp_start;
    logic [2:0]  exp_muop;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;
  vec_t vecs[8];

  // Called at a negedge. Drives one op for one cycle, then follows it to completion.
  task automatic run_txn(input string name, input logic [3:0] op, input logic [31:0] rs, rt,
                         input logic use_d, input int exp_busy, exp_start,
                         input logic [2:0] exp_muop, input logic [31:0] exp_hi, exp_lo,
                         input logic exp_err);
    int   nbusy, nstart;
    logic stall_bad;
    sb_t  s;
    e_valid = 1'b1; e_md_op = op; e_rs = rs; e_rt = rt; d_md_use = use_d;
    sbq.push_back('{hi: exp_hi, lo: exp_lo});
    #1;
    if (use_d) chk({name, " stall_at_issue"}, stall, exp_busy > 0);
    @(negedge clk);
    e_valid = 1'b0; e_md_op = OP_NONE;
    nbusy = 0; nstart = 0; stall_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!md_busy) break;
      nbusy++;
      if (mu_bus.mu_start) begin
        nstart++;
        chk({name, " mu_op"}, mu_bus.mu_op, exp_muop);
      end
      if (use_d && stall !== 1'b1) stall_bad = 1'b1;
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, nbusy, exp_busy);
    chk({name, " start_cycles"}, nstart, exp_start);
    if (use_d) begin
      chk({name, " stall_while_busy"}, stall_bad, 1'b0);
      chk({name, " stall_after"}, stall, 1'b0);
    end
    d_md_use = 1'b0;
    s = sbq.pop_front();
    chk({name, " hi"}, hi, s.hi);
    chk({name, " lo"}, lo, s.lo);
    chk({name, " md_err"}, md_err, exp_err);
  endtask

  initial begin
    vecs[0] = '{"mult_small", OP_MULT,  32'd12,       32'd16,       7, 1, 3'd1, 32'h0,        32'd192};
    vecs[1] = '{"mult_neg",   OP_MULT,  32'hFFFFBBBB, 32'h10,       7, 1, 3'd1, 32'hFFFFFFFF, 32'hFFFBBBB0};
    vecs[2] = '{"multu",      OP_MULTU, 32'hFFFFFFFF, 32'd2,        7, 1, 3'd2, 32'h1,        32'hFFFFFFFE};
    vecs[3] = '{"div_neg",    OP_DIV,   32'hFFFFFFF9, 32'd2,        7, 1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{"divu",       OP_DIVU,  32'd100,      32'd7,        7, 1, 3'd4, 32'd2,        32'd14};
    vecs[5] = '{"mthi",       OP_MTHI,  32'h1234,     32'd0,        0, 0, 3'd0, 32'h1234,     32'd14};
    vecs[6] = '{"mtlo",       OP_MTLO,  32'h5678,     32'd0,        0, 0, 3'd0, 32'h1234,     32'h5678};
    vecs[7] = '{"divu_zero",  OP_DIVU,  32'd9,        32'd0,        0, 0, 3'd0, 32'h1234,     32'h5678};

    reset = 1'b1; e_valid = 1'b0; e_flush = 1'b0; d_md_use = 1'b0;
    e_md_op = OP_NONE; e_rs = 32'd0; e_rt = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset md_err", md_err, 1'b0);
    chk("reset md_busy", md_busy, 1'b0);
    chk("reset mu_start", mu_bus.mu_start, 1'b0);
    chk("reset mu_op_a_b", {mu_bus.mu_op, mu_bus.mu_a, mu_bus.mu_b}, 67'd0);

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, vecs[i].exp_busy,
              vecs[i].exp_start, vecs[i].exp_muop, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);

    // Dependent read: MULT in E with a HI/LO op in D, then the read reaches E.
    run_txn("stall_dep", OP_MULT, 32'd12, 32'd16, 1'b1, 7, 1, 3'd1, 32'd0, 32'd192, 1'b0);
    e_md_op = OP_MFLO; e_valid = 1'b1;
    #1 chk("mflo rd_data", rd_data, 32'd192);
    e_md_op = OP_MFHI;
    #1 chk("mfhi rd_data", rd_data, 32'd0);
    e_md_op = OP_MTHI;
    #1 chk("non-read rd_data", rd_data, 32'd0);
    e_valid = 1'b0; e_md_op = OP_NONE;
    @(negedge clk);

    // Flush wins over valid.
    e_valid = 1'b1; e_flush = 1'b1; e_md_op = OP_MULT; e_rs = 32'd3; e_rt = 32'd4; d_md_use = 1'b1;
    #1 chk("flush stall", stall, 1'b0);
    @(negedge clk);
    chk("flush md_busy", md_busy, 1'b0);
    chk("flush mu_start", mu_bus.mu_start, 1'b0);
    e_md_op = OP_MTHI; e_rs = 32'hAAAA;
    @(negedge clk);
    chk("flush mthi hi", hi, 32'd0);
    e_valid = 1'b0; e_flush = 1'b0; e_md_op = OP_NONE; d_md_use = 1'b0;

    // Timeout: unit never drops busy; LAUNCH + TO WAIT cycles.
    hang = 1'b1;
    run_txn("timeout", OP_MULT, 32'd2, 32'd3, 1'b0, TO + 1, 1, 3'd1, 32'd0, 32'd192, 1'b1);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; hang = 1'b0;
    @(negedge clk);
    chk("reset clears md_err", md_err, 1'b0);

    // Reset mid-WAIT aborts the operation.
    run_txn("mthi_pre", OP_MTHI, 32'h77, 32'd0, 1'b0, 0, 0, 3'd0, 32'h77, 32'd0, 1'b0);
    e_valid = 1'b1; e_md_op = OP_MULT; e_rs = 32'd3; e_rt = 32'd5;
    @(negedge clk);
    e_valid = 1'b0; e_md_op = OP_NONE;
    repeat (2) @(negedge clk);
    chk("pre-abort md_busy", md_busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("abort md_busy", md_busy, 1'b0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort mu_start", mu_bus.mu_start, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort no capture lo", lo, 32'd0);

    // Protocol violation: MTHI issued while LAUNCH is in progress is dropped and flagged.
    e_valid = 1'b1; e_md_op = OP_MULT; e_rs = 32'd3; e_rt = 32'd5;
    sbq.push_back('{hi: 32'd0, lo: 32'd15});
    @(negedge clk);
    e_md_op = OP_MTHI; e_rs = 32'h9999;
    @(negedge clk);
    e_valid = 1'b0; e_md_op = OP_NONE;
    begin
      int k;
      for (k = 0; k < 40; k++) begin
        if (!md_busy) break;
        @(negedge clk);
      end
      chk("violation completes", k < 40, 1'b1);
    end
    begin
      sb_t s;
      s = sbq.pop_front();
      chk("violation hi", hi, s.hi);
      chk("violation lo", lo, s.lo);
    end
    chk("violation md_err", md_err, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
